// File: rtl/sdram_arb_pkg.sv
// Shared types and helpers for the SDRAM command arbiter and its read-tag FIFO.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } arb_state_e;

    // Latch fields are sized for the widest supported controller; the arbiter uses the low bits.
    localparam int unsigned CmdAddrMax = 32;
    localparam int unsigned CmdDataMax = 32;

    typedef struct packed {
        logic                  we;
        logic [CmdAddrMax-1:0] addr;
        logic [CmdDataMax-1:0] wdata;
    } sdram_cmd_t;

    function automatic int unsigned port_idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// Synchronous FIFO of requesting-port indices for outstanding reads (Depth >= 2, power of 2).
module sdram_arb_tag_fifo
    import sdram_arb_pkg::*;
#(
    parameter int unsigned Width = 2,
    parameter int unsigned Depth = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [Width-1:0] i_data,
    input  logic             i_pop,
    output logic [Width-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PtrWidth = $clog2(Depth);

    logic [Width-1:0]  r_mem [Depth];
    logic [PtrWidth:0] r_wptr;
    logic [PtrWidth:0] r_rptr;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[PtrWidth] != r_rptr[PtrWidth]) &&
                       (r_wptr[PtrWidth-1:0] == r_rptr[PtrWidth-1:0]);
    assign w_do_pop  = i_pop & ~o_empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_data    = r_mem[r_rptr[PtrWidth-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wptr[PtrWidth-1:0]] <= i_data;
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing the sdram_ctrl command port between NumPorts clients.
// Define SDRAM_ARB_FIXED_PRIO_EN for fixed priority (lowest eligible index wins).
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned NumPorts  = 4,
    parameter int unsigned AddrWidth = 22,
    parameter int unsigned DataWidth = 16,
    parameter int unsigned MaxRdOut  = 4
) (
    input  logic                          i_sys_clk,
    input  logic                          i_rst,
    input  logic [NumPorts-1:0]           i_req_valid,
    input  logic [NumPorts-1:0]           i_req_we,
    input  logic [NumPorts*AddrWidth-1:0] i_req_addr,
    input  logic [NumPorts*DataWidth-1:0] i_req_wdata,
    output logic [NumPorts-1:0]           o_req_ready,
    output logic [NumPorts-1:0]           o_rd_valid,
    output logic [DataWidth-1:0]          o_rd_data,
    output logic                          o_err_orphan,
    output logic                          o_wr_req,
    output logic                          o_rd_req,
    output logic [AddrWidth-1:0]          o_wr_addr,
    output logic [AddrWidth-1:0]          o_rd_addr,
    output logic [DataWidth-1:0]          o_wr_data,
    input  logic                          i_ctrl_ready,
    input  logic                          i_ctrl_rd_valid,
    input  logic [DataWidth-1:0]          i_ctrl_rd_data
);

    localparam int unsigned PortIdxWidth = port_idx_width(NumPorts);

    arb_state_e              r_state;
    arb_state_e              w_state_nxt;
    sdram_cmd_t              r_cmd;
    logic                    r_pulse;
    logic                    r_hold_first;
    logic [PortIdxWidth-1:0] r_port;
    logic [PortIdxWidth-1:0] w_win;
    logic                    w_any;
    logic                    w_take;
    logic [NumPorts-1:0]     w_elig;
    logic [NumPorts-1:0]     w_grant;
    logic [NumPorts-1:0]     r_rd_valid;
    logic [DataWidth-1:0]    r_rd_data;
    logic                    r_err;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic [PortIdxWidth-1:0] w_fifo_head;
    logic                    w_unused_cmd_bits;

    assign w_elig = i_req_valid & (i_req_we | {NumPorts{~w_fifo_full}});

`ifdef SDRAM_ARB_FIXED_PRIO_EN
    always_comb begin
        w_win = '0;
        w_any = 1'b0;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            if (!w_any && w_elig[i]) begin
                w_win = PortIdxWidth'(i);
                w_any = 1'b1;
            end
        end
    end
`else
    logic [PortIdxWidth-1:0] r_rr_ptr;

    always_comb begin
        int unsigned idx;
        idx   = 0;
        w_win = '0;
        w_any = 1'b0;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            idx = (32'(r_rr_ptr) + i) % NumPorts;
            if (!w_any && w_elig[idx]) begin
                w_win = PortIdxWidth'(idx);
                w_any = 1'b1;
            end
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_rr_ptr <= '0;
        end else if (w_take) begin
            r_rr_ptr <= (w_win == PortIdxWidth'(NumPorts - 1)) ? '0 : w_win + PortIdxWidth'(1);
        end
    end
`endif

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Grants are suppressed while reset is held so no command transfers into a clearing latch.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = '0;
        w_take      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!i_rst && i_ctrl_ready && w_any) begin
                    w_take      = 1'b1;
                    w_grant     = NumPorts'(1) << w_win;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: w_state_nxt = HOLD;
            HOLD: begin
                if (!r_hold_first && i_ctrl_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_cmd        <= '0;
            r_port       <= '0;
            r_pulse      <= 1'b0;
            r_hold_first <= 1'b0;
        end else begin
            r_pulse      <= w_take;
            r_hold_first <= (r_state == ISSUE);
            if (w_take) begin
                r_cmd.we    <= i_req_we[w_win];
                r_cmd.addr  <= CmdAddrMax'(i_req_addr[w_win*AddrWidth +: AddrWidth]);
                r_cmd.wdata <= CmdDataMax'(i_req_wdata[w_win*DataWidth +: DataWidth]);
                r_port      <= w_win;
            end
        end
    end

    assign w_push = r_pulse & ~r_cmd.we;
    assign w_pop  = i_ctrl_rd_valid & ~w_fifo_empty;

    sdram_arb_tag_fifo #(
        .Width(PortIdxWidth),
        .Depth(MaxRdOut)
    ) u_tag_fifo (
        .i_clk  (i_sys_clk),
        .i_rst  (i_rst),
        .i_push (w_push),
        .i_data (r_port),
        .i_pop  (w_pop),
        .o_data (w_fifo_head),
        .o_full (w_fifo_full),
        .o_empty(w_fifo_empty)
    );

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_rd_valid <= '0;
            r_rd_data  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_rd_valid <= '0;
            if (w_pop) begin
                r_rd_valid <= NumPorts'(1) << w_fifo_head;
                r_rd_data  <= i_ctrl_rd_data;
            end
            if (i_ctrl_rd_valid && w_fifo_empty) r_err <= 1'b1;
        end
    end

    assign w_unused_cmd_bits = ^{r_cmd.addr, r_cmd.wdata};

    assign o_req_ready  = w_grant;
    assign o_wr_req     = r_pulse & r_cmd.we;
    assign o_rd_req     = r_pulse & ~r_cmd.we;
    assign o_wr_addr    = r_cmd.addr[AddrWidth-1:0];
    assign o_rd_addr    = r_cmd.addr[AddrWidth-1:0];
    assign o_wr_data    = r_cmd.wdata[DataWidth-1:0];
    assign o_rd_valid   = r_rd_valid;
    assign o_rd_data    = r_rd_data;
    assign o_err_orphan = r_err;

endmodule
